// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared cell/player codes, segment glyphs and FSM states for the board display
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] PLAYER_NONE = 2'b00;
  localparam logic [1:0] PLAYER_1    = 2'b01;
  localparam logic [1:0] PLAYER_2    = 2'b10;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_I     = 7'h79;

  typedef enum logic [1:0] {TURN, ILL, WIN} state_t;

  function automatic logic [6:0] player_glyph(input logic [1:0] p);
    case (p)
      PLAYER_1: player_glyph = SEG_1;
      PLAYER_2: player_glyph = SEG_2;
      default:  player_glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/ttt_blink_gen.sv
// rtl/ttt_blink_gen.sv - blink prescaler with synchronous restart
// blink_next is the blink phase that becomes current at the coming edge.
module ttt_blink_gen import ttt_pkg::*; #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic blink_next
);

  localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(BLINK_DIV - 1);

  logic [PW-1:0] pre, pre_next;
  logic          blink_on;

  always_comb begin
    pre_next   = pre + PW'(1);
    blink_next = blink_on;
    if (restart) begin
      pre_next   = '0;
      blink_next = 1'b1;
    end else if (pre == PRE_MAX) begin
      pre_next   = '0;
      blink_next = ~blink_on;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre      <= '0;
      blink_on <= 1'b1;
    end else begin
      pre      <= pre_next;
      blink_on <= blink_next;
    end
  end

endmodule

// File: rtl/ttt_display_seq.sv
// rtl/ttt_display_seq.sv - registered tic-tac-toe LED/7-segment driver
// Shows turn, timed ILL message and winner; blinks the winning line.
module ttt_display_seq import ttt_pkg::*; #(
  parameter int CELLS     = 9,
  parameter int BLINK_DIV = 25000000,
  parameter int ILL_HOLD  = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*CELLS-1:0] board,
  input  logic [1:0]         who,
  input  logic               ill,
  input  logic               win_valid,
  input  logic [CELLS-1:0]   win_mask,
  input  logic [1:0]         win_who,
  output logic [2*CELLS-1:0] led,
  output logic [6:0]         hex0,
  output logic [6:0]         hex1,
  output logic [6:0]         hex2,
  output logic [6:0]         hex3,
  output logic [6:0]         hex4,
  output logic [6:0]         hex5
);

  localparam int TW = $clog2(ILL_HOLD + 1);
  localparam logic [TW-1:0] ILL_LOAD = TW'(ILL_HOLD - 1);

  state_t             state, state_next;
  logic [TW-1:0]      timer, timer_next;
  logic               win_valid_q;
  logic               blink_next;
  logic [2*CELLS-1:0] led_next;
  logic [6:0]         hex_next [6];

  ttt_blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk       (clk),
    .rst       (rst),
    .restart   (win_valid & ~win_valid_q),
    .blink_next(blink_next)
  );

  always_comb begin
    state_next = state;
    timer_next = timer;
    if (win_valid) begin
      state_next = WIN;
      timer_next = '0;
    end else if (state == WIN) begin
      state_next = TURN;
    end else if (ill) begin
      state_next = ILL;
      timer_next = ILL_LOAD;
    end else if (state == ILL) begin
      if (timer == '0) state_next = TURN;
      else             timer_next = timer - TW'(1);
    end
  end

  // Hex is registered from the state being entered so ILL shows for exactly ILL_HOLD cycles.
  always_comb begin
    for (int k = 0; k < 6; k++) hex_next[k] = SEG_BLANK;
    case (state_next)
      ILL: begin
        hex_next[2] = SEG_I;
        hex_next[1] = SEG_L;
        hex_next[0] = SEG_L;
      end
      WIN: begin
        hex_next[5] = SEG_P;
        hex_next[4] = player_glyph(win_who);
      end
      default: begin
        hex_next[1] = SEG_P;
        hex_next[0] = player_glyph(who);
      end
    endcase
  end

  always_comb begin
    led_next = '0;
    for (int i = 0; i < CELLS; i++) begin
      logic lit;
      lit = ~(win_valid & win_mask[i]) | blink_next;
      led_next[i]         = (board[2*i +: 2] == CELL_X) & lit;
      led_next[CELLS + i] = (board[2*i +: 2] == CELL_O) & lit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TURN;
      timer       <= '0;
      win_valid_q <= 1'b0;
      led         <= '0;
      hex0        <= SEG_BLANK;
      hex1        <= SEG_BLANK;
      hex2        <= SEG_BLANK;
      hex3        <= SEG_BLANK;
      hex4        <= SEG_BLANK;
      hex5        <= SEG_BLANK;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      win_valid_q <= win_valid;
      led         <= led_next;
      hex0        <= hex_next[0];
      hex1        <= hex_next[1];
      hex2        <= hex_next[2];
      hex3        <= hex_next[3];
      hex4        <= hex_next[4];
      hex5        <= hex_next[5];
    end
  end

endmodule

// File: tb/tb_ttt_display_seq.sv
// tb/tb_ttt_display_seq.sv - self-checking bench for ttt_display_seq
// Reference model tracks ILL cycles left and cycles since blink restart.
module tb_ttt_display_seq;

  localparam int CELLS = 9;
  localparam int BLINK_DIV = 4;
  localparam int ILL_HOLD = 5;

  logic clk = 1'b0;
  logic rst;
  logic [2*CELLS-1:0] board;
  logic [1:0] who, win_who;
  logic ill, win_valid;
  logic [CELLS-1:0] win_mask;
  logic [2*CELLS-1:0] led;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  ttt_display_seq #(.CELLS(CELLS), .BLINK_DIV(BLINK_DIV), .ILL_HOLD(ILL_HOLD)) dut (
    .clk(clk), .rst(rst), .board(board), .who(who), .ill(ill),
    .win_valid(win_valid), .win_mask(win_mask), .win_who(win_who),
    .led(led), .hex0(hex0), .hex1(hex1), .hex2(hex2),
    .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit(input logic [1:0] p);
    if (p == 2'b01) return 7'h79;
    if (p == 2'b10) return 7'h24;
    return 7'h7F;
  endfunction

  // Reference model
  logic [2*CELLS-1:0] m_led = '0;
  logic [6:0] m_hex [6] = '{default: 7'h7F};
  int  ill_left = 0;
  int  phase = 0;
  bit  m_win = 1'b0;
  bit  wv_prev = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_led = '0;
      for (int k = 0; k < 6; k++) m_hex[k] = 7'h7F;
      ill_left = 0;
      phase = 0;
      m_win = 1'b0;
      wv_prev = 1'b0;
    end else begin
      bit blink;
      if (win_valid && !wv_prev) phase = 0;
      else phase = phase + 1;
      wv_prev = win_valid;
      blink = ((phase / BLINK_DIV) % 2) == 0;

      if (win_valid) begin
        m_win = 1'b1;
        ill_left = 0;
      end else if (m_win) m_win = 1'b0;
      else if (ill) ill_left = ILL_HOLD;
      else if (ill_left > 0) ill_left = ill_left - 1;

      for (int k = 0; k < 6; k++) m_hex[k] = 7'h7F;
      if (m_win) begin
        m_hex[5] = 7'h0C;
        m_hex[4] = digit(win_who);
      end else if (ill_left > 0) begin
        m_hex[2] = 7'h79;
        m_hex[1] = 7'h47;
        m_hex[0] = 7'h47;
      end else begin
        m_hex[1] = 7'h0C;
        m_hex[0] = digit(who);
      end

      m_led = '0;
      for (int i = 0; i < CELLS; i++) begin
        bit lit;
        lit = !(win_valid && win_mask[i]) || blink;
        if (board[2*i +: 2] == 2'b01) m_led[i] = lit;
        if (board[2*i +: 2] == 2'b10) m_led[CELLS + i] = lit;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_led", 32'(led), 32'(m_led));
      check("model_hex0", 32'(hex0), 32'(m_hex[0]));
      check("model_hex1", 32'(hex1), 32'(m_hex[1]));
      check("model_hex2", 32'(hex2), 32'(m_hex[2]));
      check("model_hex3", 32'(hex3), 32'(m_hex[3]));
      check("model_hex4", 32'(hex4), 32'(m_hex[4]));
      check("model_hex5", 32'(hex5), 32'(m_hex[5]));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ill();
    ill = 1'b1;
    step(1);
    ill = 1'b0;
  endtask

  task automatic expect_ill_then_turn(input string tag);
    for (int c = 0; c < ILL_HOLD; c++) begin
      check({tag, "_hex2"}, 32'(hex2), 32'h79);
      check({tag, "_hex0"}, 32'(hex0), 32'h47);
      if (c < ILL_HOLD - 1) step(1);
    end
    step(1);
    check({tag, "_end_hex2"}, 32'(hex2), 32'h7F);
    check({tag, "_end_hex1"}, 32'(hex1), 32'h0C);
  endtask

  initial begin
    rst = 1'b1; board = '0; who = 2'b00; ill = 1'b0;
    win_valid = 1'b0; win_mask = '0; win_who = 2'b00;
    step(1);
    cmp_en = 1'b1;
    step(1);
    check("reset_led", 32'(led), 32'h0);
    check("reset_hex0", 32'(hex0), 32'h7F);
    check("reset_hex5", 32'(hex5), 32'h7F);

    // Board decode and turn display
    rst = 1'b0;
    board = 18'h30201;
    who = 2'b10;
    step(1);
    check("decode_led", 32'(led), 32'h2001);
    check("turn_hex1", 32'(hex1), 32'h0C);
    check("turn_hex0_p2", 32'(hex0), 32'h24);
    who = 2'b00;
    step(1);
    check("turn_hex0_none", 32'(hex0), 32'h7F);
    who = 2'b01;
    step(1);
    check("turn_hex0_p1", 32'(hex0), 32'h79);

    // Single ILL pulse
    pulse_ill();
    expect_ill_then_turn("ill_single");

    // Retrigger in the third ILL cycle
    pulse_ill();
    step(2);
    check("retrig_pre_hex2", 32'(hex2), 32'h79);
    pulse_ill();
    expect_ill_then_turn("ill_retrig");

    // Winning line blink
    board = 18'h10121;
    win_mask = 9'h111;
    win_who = 2'b01;
    win_valid = 1'b1;
    step(1);
    for (int c = 0; c < 12; c++) begin
      check("blink_led", 32'(led), (((c / 4) % 2) == 0) ? 32'h911 : 32'h800);
      if (c == 0) begin
        check("win_hex5", 32'(hex5), 32'h0C);
        check("win_hex4", 32'(hex4), 32'h79);
        check("win_hex1", 32'(hex1), 32'h7F);
      end
      step(1);
    end
    pulse_ill();
    check("win_ignore_ill_hex5", 32'(hex5), 32'h0C);
    check("win_ignore_ill_hex2", 32'(hex2), 32'h7F);
    win_valid = 1'b0;
    step(1);
    check("win_drop_hex5", 32'(hex5), 32'h7F);
    check("win_drop_hex1", 32'(hex1), 32'h0C);
    check("win_drop_led", 32'(led), 32'h911);

    // ill and win_valid rise together
    ill = 1'b1;
    win_valid = 1'b1;
    step(1);
    ill = 1'b0;
    check("collide_hex5", 32'(hex5), 32'h0C);
    check("collide_hex2", 32'(hex2), 32'h7F);
    win_valid = 1'b0;
    step(1);
    check("collide_turn_hex1", 32'(hex1), 32'h0C);
    check("collide_turn_hex2", 32'(hex2), 32'h7F);

    // Reset during ILL with timer at 3
    pulse_ill();
    step(1);
    rst = 1'b1;
    step(1);
    check("midrst_hex2", 32'(hex2), 32'h7F);
    check("midrst_hex1", 32'(hex1), 32'h7F);
    check("midrst_led", 32'(led), 32'h0);
    rst = 1'b0;
    step(1);
    check("post_rst_hex1", 32'(hex1), 32'h0C);
    pulse_ill();
    expect_ill_then_turn("ill_after_rst");

    step(2);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
